// File: rtl/ysyx_regfile_sb.sv
// ysyx_regfile_sb: multi-port integer register file with a write-pending scoreboard.
// Decode/issue reads operands and marks destinations busy. Writeback writes data
// and clears the busy bit. Reads are combinational, with optional same-cycle
// forwarding of the writeback data.
//
// Port protocol (no valid/ready handshake is involved):
//   - wr_en is a one-cycle strobe. Every asserted cycle is accepted and nothing
//     can back-pressure it.
//   - set_en is a one-cycle strobe. Every asserted cycle is accepted.
//   - flush is a one-cycle strobe that clears every busy bit.
//   - All outputs are valid in every cycle.
module ysyx_regfile_sb #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int NR_READ  = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [AW-1:0]           waddr,
  input  logic [XLEN-1:0]         wdata,
  input  logic [NR_READ*AW-1:0]   raddr,
  output logic [NR_READ*XLEN-1:0] rdata,
  output logic [NR_READ-1:0]      rd_busy,
  input  logic                    set_en,
  input  logic [AW-1:0]           set_addr,
  input  logic                    flush,
  output logic [(1<<AW)-1:0]      busy,
  output logic [31:0]             wb_cnt
);

  localparam int DEPTH = 1 << AW;

  logic [XLEN-1:0]  rf [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [31:0]      wb_cnt_q;
  logic             wr_ok;
  logic             set_ok;

  // When ZERO_REG is set, register 0 is hardwired. Writes to it are dropped and
  // are not counted. Busy-sets to it are ignored.
  assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (waddr == '0));
  assign set_ok = set_en && !((ZERO_REG != 0) && (set_addr == '0));

  // Register storage: cleared by reset, written on an accepted writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        rf[r] <= '0;
      end
    end else if (wr_ok) begin
      rf[waddr] <= wdata;
    end
  end

  // Accepted-write counter. It wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_cnt_q <= '0;
    end else if (wr_ok) begin
      wb_cnt_q <= wb_cnt_q + 32'd1;
    end
  end

  // Scoreboard next state. Flush beats set, and set beats the writeback clear.
  // A writeback to the register that is issuing again must leave it busy.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_en)  busy_d[waddr]    = 1'b0;
      if (set_ok) busy_d[set_addr] = 1'b1;
    end
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign wb_cnt = wb_cnt_q;

  // Read ports.
  // Register 0 reads as zero first. Same-cycle writeback data is forwarded next.
  // Otherwise the port returns the stored value.
  // A forwarded operand is already available, so the port does not report busy.
  // Reads are also held at zero while reset is asserted.
  for (genvar i = 0; i < NR_READ; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;
    logic          is_zero;

    assign ra      = raddr[i*AW +: AW];
    assign hit     = (BYPASS != 0) && wr_en && (waddr == ra);
    assign is_zero = (ZERO_REG != 0) && (ra == '0);

    assign rdata[i*XLEN +: XLEN] = (rst || is_zero) ? '0 :
                                   hit              ? wdata :
                                                      rf[ra];
    assign rd_busy[i] = busy_q[ra] && !hit && !is_zero;
  end

endmodule

// File: tb/tb_ysyx_regfile_sb.sv
// Testbench for ysyx_regfile_sb with the default parameters
// (two read ports, hardwired x0, bypass enabled). It runs directed scenarios
// and then a randomized run. Every result is compared against a behavioural
// model kept in this file.
module tb_ysyx_regfile_sb;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                 wr_en;
  logic [AW-1:0]        waddr;
  logic [XLEN-1:0]      wdata;
  logic [NR*AW-1:0]     raddr;
  logic [NR*XLEN-1:0]   rdata;
  logic [NR-1:0]        rd_busy;
  logic                 set_en;
  logic [AW-1:0]        set_addr;
  logic                 flush;
  logic [DEPTH-1:0]     busy;
  logic [31:0]          wb_cnt;

  ysyx_regfile_sb #(
    .XLEN(XLEN), .AW(AW), .NR_READ(NR), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rd_busy(rd_busy),
    .set_en(set_en), .set_addr(set_addr), .flush(flush),
    .busy(busy), .wb_cnt(wb_cnt)
  );

  // ---------------- reference model ----------------
  int unsigned   errors = 0;
  int unsigned   checks = 0;
  logic [31:0]   m_rf   [DEPTH];
  bit            m_busy [DEPTH];
  logic [31:0]   m_cnt;

  function automatic void model_reset();
    for (int r = 0; r < DEPTH; r++) begin
      m_rf[r]   = '0;
      m_busy[r] = 1'b0;
    end
    m_cnt = '0;
  endfunction

  // Apply one clock edge's worth of architectural effect.
  // The clear is applied before the set, so the new producer wins.
  function automatic void model_edge();
    if (wr_en && waddr != 0) begin
      m_rf[waddr] = wdata;
      m_cnt       = m_cnt + 1;
    end
    if (flush) begin
      for (int r = 0; r < DEPTH; r++) m_busy[r] = 1'b0;
    end else begin
      if (wr_en) m_busy[waddr] = 1'b0;
      if (set_en && set_addr != 0) m_busy[set_addr] = 1'b1;
    end
  endfunction

  function automatic logic [31:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wr_en && waddr == a) return wdata;
    return m_rf[a];
  endfunction

  function automatic logic exp_rb(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    if (wr_en && waddr == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [DEPTH-1:0] exp_busy_vec();
    logic [DEPTH-1:0] v;
    for (int r = 0; r < DEPTH; r++) v[r] = m_busy[r];
    return v;
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_comb(input string tag);
    logic [AW-1:0] a;
    for (int i = 0; i < NR; i++) begin
      a = raddr[i*AW +: AW];
      check($sformatf("%s rdata%0d a=%0d", tag, i, a), {32'd0, rdata[i*XLEN +: XLEN]}, {32'd0, exp_rd(a)});
      check($sformatf("%s rd_busy%0d a=%0d", tag, i, a), {63'd0, rd_busy[i]}, {63'd0, exp_rb(a)});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    wr_en = 0; waddr = '0; wdata = '0; set_en = 0; set_addr = '0; flush = 0;
  endtask

  // Call this at a negedge with the inputs already driven. It checks the
  // combinational outputs, clocks one edge, then checks the state outputs.
  task automatic step(input string tag);
    #1;
    check_comb(tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, " busy"},   {32'd0, busy},   {32'd0, exp_busy_vec()});
    check({tag, " wb_cnt"}, {32'd0, wb_cnt}, {32'd0, m_cnt});
    @(negedge clk);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    idle();
    raddr = '0;
    rst   = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state: every register reads 0 on both ports, nothing is busy.
    for (int a = 0; a < DEPTH; a++) begin
      raddr = {AW'(DEPTH - 1 - a), AW'(a)};
      #1;
      check($sformatf("rst rd0 a=%0d", a), {32'd0, rdata[31:0]},  64'd0);
      check($sformatf("rst rd1 a=%0d", a), {32'd0, rdata[63:32]}, 64'd0);
      @(negedge clk);
    end
    check("rst busy",   {32'd0, busy},   64'd0);
    check("rst wb_cnt", {32'd0, wb_cnt}, 64'd0);

    // A write is forwarded to a read in the same cycle.
    wr_en = 1; waddr = 5; wdata = 32'hDEADBEEF; raddr = {AW'(5), AW'(5)};
    #1;
    check("bypass rd0", {32'd0, rdata[31:0]},  {32'd0, 32'hDEADBEEF});
    check("bypass rd1", {32'd0, rdata[63:32]}, {32'd0, 32'hDEADBEEF});
    step("bypass");
    idle();
    #1;
    check("stored r5", {32'd0, rdata[31:0]}, {32'd0, 32'hDEADBEEF});

    // Register 0 is hardwired: the write is dropped and a busy-set is ignored.
    wr_en = 1; waddr = 0; wdata = 32'h1234; set_en = 1; set_addr = 0; raddr = '0;
    #1;
    check("x0 bypass", {32'd0, rdata[31:0]}, 64'd0);
    step("x0");
    check("x0 wb_cnt", {32'd0, wb_cnt}, 64'd1);
    check("x0 busy0",  {63'd0, busy[0]}, 64'd0);
    idle();

    // Issue x7. It shows busy on the next cycle and clears on writeback.
    set_en = 1; set_addr = 7;
    step("sb set7");
    idle(); raddr = {AW'(7), AW'(0)};
    #1;
    check("sb rd_busy1 N+1", {63'd0, rd_busy[1]}, 64'd1);
    step("sb N+1");
    step("sb N+2");
    wr_en = 1; waddr = 7; wdata = 32'hA5A5_0007;
    #1;
    check("sb rd_busy1 N+3", {63'd0, rd_busy[1]}, 64'd0);
    step("sb N+3");
    check("sb busy7 after", {63'd0, busy[7]}, 64'd0);
    idle();

    // Set and clear in the same cycle: the set wins, and flush beats the set.
    set_en = 1; set_addr = 9; wr_en = 1; waddr = 9; wdata = 32'h99;
    step("set+clr 9");
    check("set+clr busy9", {63'd0, busy[9]}, 64'd1);
    flush = 1;
    step("flush");
    check("flush busy", {32'd0, busy}, 64'd0);
    idle();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      wr_en    = ($urandom_range(0, 2) != 0);
      waddr    = rand_addr();
      wdata    = $urandom();
      set_en   = ($urandom_range(0, 2) != 0);
      set_addr = rand_addr();
      flush    = ($urandom_range(0, 40) == 0);
      raddr    = {rand_addr(), rand_addr()};
      if ($urandom_range(0, 4) == 0) raddr = {waddr, waddr};
      step("rand");
    end
    idle();

    // Asynchronous reset in the middle of a cycle clears everything at once.
    flush = 1; step("pre-rst flush"); idle();
    for (int r = 7; r <= 11; r++) begin
      set_en = 1; set_addr = AW'(r); wr_en = 1; waddr = AW'(r - 6); wdata = 32'h100 + r;
      step("pre-rst");
    end
    idle();
    check("pre-rst busy", {32'd0, busy}, 64'h0000_0F80);
    wr_en = 1; waddr = 3; wdata = 32'hCAFE; raddr = {AW'(3), AW'(1)};
    #2;
    rst = 1'b1;
    #1;
    check("async busy",    {32'd0, busy},    64'd0);
    check("async rd0",     {32'd0, rdata[31:0]},  64'd0);
    check("async rd1",     {32'd0, rdata[63:32]}, 64'd0);
    check("async wb_cnt",  {32'd0, wb_cnt},  64'd0);
    check("async rd_busy", {62'd0, rd_busy}, 64'd0);
    model_reset();
    idle();
    @(negedge clk);
    rst = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      raddr = {AW'(r), AW'(r + 6)};
      step("post-rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
